mem_dump_tx: RTL and testbench
==============================

# mem_dump_tx

Memory read-back streamer; the transmit-direction counterpart of the serial memory loader. On a start pulse it reads a contiguous range of 64-bit words from memory port b and emits each word as 8 bytes, least-significant byte first, into the SPART transmit path through a byte strobe gated by transmit-buffer-ready. It sits beside the loader's driver, shares port b with it under top-level arbitration, and lets the host verify or dump memory contents after `mem_sys_fin`.

## Interface
- `ADDR_W`, 14: memory word-address width.
- `CNT_W`, 15: word-count width; allows a full 2^14-word dump.
- `clk`  in  1: system clock (100 MHz).
- `rst`  in  1: reset, asynchronous, active-high.
- `start`  in  1: one-cycle request; sampled only in IDLE.
- `base_addr`  in  ADDR_W: first word address; sampled with `start`.
- `word_count`  in  CNT_W: number of words to send; sampled with `start`.
- `enb`  out  1: port-b enable; high only in RD.
- `web`  out  1: port-b write enable; constant 0.
- `addrb`  out  ADDR_W: port-b word address (registered current address).
- `doutb`  in  64: port-b read data; valid one cycle after the `enb` cycle.
- `tbr`  in  1: SPART transmit buffer ready.
- `tx_wr`  out  1: one-cycle byte-write strobe to the SPART.
- `tx_data`  out  8: byte accompanying `tx_wr`.
- `busy`  out  1: high from the cycle after `start` is accepted until DONE exits.
- `done`  out  1: one-cycle pulse at completion.

## Operation
- States: IDLE, RD, WAIT, SEND, GAP, DONE.
- IDLE: `start`=1 latches `addr<=base_addr` and `remaining<=word_count`.
  - If `word_count`=0, go to DONE; otherwise go to RD.
  - `start` outside IDLE is ignored.
- RD: `enb`=1, `addrb`=`addr`, for exactly one cycle; then WAIT.
- WAIT: at the end of the cycle, capture `doutb` into a 64-bit shift register and clear the byte counter to 0; then SEND.
- SEND: wait for `tbr`=1. On an edge where `tbr`=1:
  - register `tx_data<=shift[7:0]` and `tx_wr<=1`;
  - shift right by 8 and increment the byte counter;
  - go to GAP.
- GAP: two cycles. In the first, `tx_wr` is high. In the second, `tx_wr` is low. `tbr` is ignored in both, covering SPART's `tbr` fall latency. Then:
  - byte counter <8: go to SEND;
  - byte counter =8 and `remaining`>1: `addr<=addr+1` (wraps modulo 2^ADDR_W), decrement `remaining`, go to RD;
  - byte counter =8 and `remaining`=1: go to DONE.
- DONE: `done`=1 for one cycle, `busy` drops, return to IDLE.
- Byte order per word: `doutb[7:0]` first, `doutb[63:56]` last. Total bytes sent = 8 × `word_count`.
- The block never writes memory: `web`=0 and `dinb` is not driven.

## Timing
- Reset (asynchronous, any state) forces IDLE, and on the same reset assertion sets:
  - `enb`=0, `web`=0, `addrb`=0, `tx_wr`=0, `tx_data`=0x00, `busy`=0, `done`=0;
  - shift register, counters and `remaining` cleared.
- Reset mid-transfer abandons the transfer. No partial-byte strobe is produced after reset releases.
- All outputs are registered; no combinational path from inputs to outputs.
- `start` at edge T0:
  - `busy`=1 and state RD during T0+1 (`enb`=1);
  - WAIT at T0+2;
  - first SEND cycle at T0+3.
- With `tbr` held at 1:
  - first `tx_wr` at T0+4;
  - strobes every 3 cycles thereafter;
  - the next word's RD follows the 8th strobe's GAP, i.e. 2 cycles after it.
  - Per-word period is 8×3+2 = 26 cycles.
- With `tbr`=0, SEND holds indefinitely with `tx_wr`=0. No timeout.
- `done` pulses the cycle after the final GAP, or at T0+1 when `word_count`=0; `busy` stays 0 throughout that case.
- `tx_data` holds its last value between strobes.

## Test plan
- Reset mid-SEND (assert `rst` between strobes of byte 3) -> all outputs go to reset values immediately; no `tx_wr` after release; next `start` behaves normally.
- Single word, memory[0x0010]=0x8877665544332211, `tbr`=1, `base_addr`=0x0010, `word_count`=1:
  - -> `enb` one cycle at T0+1 with `addrb`=0x0010;
  - -> bytes 0x11,0x22,…,0x88 on 8 strobes, first at T0+4, spaced 3 cycles;
  - -> `done` pulses once.
- Backpressure: same word, `tbr` low for 10 cycles before byte 4 -> exactly 8 strobes, correct order, no duplicate or dropped byte.
- Wrap: `base_addr`=0x3FFF, `word_count`=2 -> reads at 0x3FFF then 0x0000; 16 bytes; second word's RD occurs 2 cycles after the 8th strobe's GAP.
- `word_count`=0 -> `done` at T0+1, no `enb`, no `tx_wr`, `busy` never high.
- `start` pulsed while busy (word 2 of 3) -> ignored; exactly 24 bytes sent and one `done`.

Source files
------------

// File: rtl/mem_dump_tx.sv
// Memory read-back streamer: reads word_count 64-bit words from port b starting at base_addr
// and emits each one as 8 bytes, LSB first, on the SPART transmit strobe gated by tbr.
module mem_dump_tx #(
    parameter int ADDR_W = 14,
    parameter int CNT_W  = 15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [CNT_W-1:0]  word_count_i,
    output logic              enb_o,
    output logic              web_o,
    output logic [ADDR_W-1:0] addrb_o,
    input  logic [63:0]       doutb_i,
    input  logic              tbr_i,
    output logic              tx_wr_o,
    output logic [7:0]        tx_data_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_SEND,
        S_GAP,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  remaining_q;
    logic [63:0]       shift_q;
    logic [3:0]        byte_cnt_q;
    logic              enb_q;
    logic              tx_wr_q;
    logic [7:0]        tx_data_q;
    logic              busy_q;
    logic              done_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            shift_q     <= '0;
            byte_cnt_q  <= '0;
            enb_q       <= 1'b0;
            tx_wr_q     <= 1'b0;
            tx_data_q   <= 8'h00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        addr_q      <= base_addr_i;
                        remaining_q <= word_count_i;
                        if (word_count_i == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_RD;
                            enb_q   <= 1'b1;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                S_RD: begin
                    enb_q   <= 1'b0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    shift_q    <= doutb_i;
                    byte_cnt_q <= 4'd0;
                    state_q    <= S_SEND;
                end
                S_SEND: begin
                    if (tbr_i) begin
                        tx_data_q  <= shift_q[7:0];
                        tx_wr_q    <= 1'b1;
                        shift_q    <= {8'h00, shift_q[63:8]};
                        byte_cnt_q <= byte_cnt_q + 4'd1;
                        state_q    <= S_GAP;
                    end
                end
                S_GAP: begin
                    // The strobe itself marks the first gap cycle; tbr is ignored for both
                    // cycles while the SPART drops its ready flag.
                    if (tx_wr_q) begin
                        tx_wr_q <= 1'b0;
                    end else if (byte_cnt_q != 4'd8) begin
                        state_q <= S_SEND;
                    end else if (remaining_q > CNT_W'(1)) begin
                        addr_q      <= addr_q + ADDR_W'(1);
                        remaining_q <= remaining_q - CNT_W'(1);
                        enb_q       <= 1'b1;
                        state_q     <= S_RD;
                    end else begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign enb_o     = enb_q;
    assign web_o     = 1'b0;
    assign addrb_o   = addr_q;
    assign tx_wr_o   = tx_wr_q;
    assign tx_data_o = tx_data_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;

endmodule

// File: tb/tb_mem_dump_tx.sv
// Directed bench for mem_dump_tx: table of transfers plus hand-written reset-mid-transfer sequence.
module tb_mem_dump_tx;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [13:0] base_addr_i;
    logic [14:0] word_count_i;
    logic        enb_o;
    logic        web_o;
    logic [13:0] addrb_o;
    logic [63:0] doutb_i;
    logic        tbr_i;
    logic        tx_wr_o;
    logic [7:0]  tx_data_o;
    logic        busy_o;
    logic        done_o;

    mem_dump_tx #(.ADDR_W(14), .CNT_W(15)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .base_addr_i(base_addr_i),
        .word_count_i(word_count_i), .enb_o(enb_o), .web_o(web_o), .addrb_o(addrb_o),
        .doutb_i(doutb_i), .tbr_i(tbr_i), .tx_wr_o(tx_wr_o), .tx_data_o(tx_data_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic logic [63:0] mem_f(input logic [13:0] a);
        logic [63:0] w;
        if (a == 14'h0010) return 64'h8877665544332211;
        for (int b = 0; b < 8; b++) w[8*b +: 8] = a[7:0] + 8'(b);
        return w;
    endfunction

    always @(posedge clk_i) if (enb_o) doutb_i <= mem_f(addrb_o);

    // Transaction monitor, sampled on the falling edge.
    logic        clr = 1'b0;
    logic [7:0]  byte_q[$];
    int          byte_cyc[$];
    logic [13:0] enb_addr[$];
    int          enb_cyc[$];
    int          done_cnt, done_cyc;
    logic        done_busy, busy_seen;

    always @(negedge clk_i) begin
        if (clr) begin
            byte_q.delete(); byte_cyc.delete(); enb_addr.delete(); enb_cyc.delete();
            done_cnt = 0; done_cyc = 0; done_busy = 1'b0; busy_seen = 1'b0;
        end else if (!rst_i) begin
            if (tx_wr_o) begin byte_q.push_back(tx_data_o); byte_cyc.push_back(cyc); end
            if (enb_o) begin enb_addr.push_back(addrb_o); enb_cyc.push_back(cyc); end
            if (done_o) begin done_cnt++; done_cyc = cyc; done_busy = busy_o; end
            if (busy_o) busy_seen = 1'b1;
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic clear_mon();
        clr = 1'b1;
        @(negedge clk_i);
        #1 clr = 1'b0;
    endtask

    typedef struct {
        logic [13:0] base;
        logic [14:0] count;
        int          stall_at;   // bytes already sent when tbr drops for 10 cycles; 0 = none
        bit          poke;       // pulse start again after 10 bytes
        logic [7:0]  first_b;
        logic [7:0]  last_b;
    } vec_t;

    task automatic run_vec(input vec_t v);
        int          t0, exp_n, err, stall_left, budget;
        bit          stalled, poked;
        logic [7:0]  exp_b[$];
        logic [13:0] ea;
        logic [63:0] w;
        clear_mon();
        exp_n = 8 * int'(v.count);
        for (int i = 0; i < int'(v.count); i++) begin
            ea = v.base + 14'(i);
            w  = mem_f(ea);
            for (int b = 0; b < 8; b++) exp_b.push_back(w[8*b +: 8]);
        end
        t0 = cyc;
        start_i = 1'b1; base_addr_i = v.base; word_count_i = v.count;
        @(negedge clk_i);
        #1 start_i = 1'b0;
        stalled = 1'b0; poked = 1'b0; stall_left = 0;
        budget = 40 * int'(v.count) + 60;
        for (int k = 0; k < budget && done_cnt == 0; k++) begin
            if (v.stall_at > 0 && !stalled && byte_q.size() == v.stall_at) begin
                tbr_i = 1'b0; stalled = 1'b1; stall_left = 10;
            end else if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) tbr_i = 1'b1;
            end
            if (v.poke && !poked && byte_q.size() == 10) begin
                start_i = 1'b1; base_addr_i = 14'h0; word_count_i = 15'd5; poked = 1'b1;
            end else begin
                start_i = 1'b0;
            end
            @(negedge clk_i);
            #1;
        end
        start_i = 1'b0; tbr_i = 1'b1;
        repeat (6) @(negedge clk_i);
        #1;
        chk("done_count", done_cnt, 1);
        chk("byte_count", byte_q.size(), exp_n);
        chk("enb_count", enb_cyc.size(), int'(v.count));
        chk("busy_after", busy_o, 0);
        if (v.count == 0) begin
            chk("zero_done_cycle", done_cyc - t0, 1);
            chk("zero_busy_seen", busy_seen, 0);
        end else if (byte_q.size() == exp_n && enb_cyc.size() == int'(v.count)) begin
            chk("first_byte", byte_q[0], v.first_b);
            chk("last_byte", byte_q[exp_n-1], v.last_b);
            err = 0;
            for (int i = 0; i < exp_n; i++) if (byte_q[i] !== exp_b[i]) err++;
            chk("byte_sequence_errors", err, 0);
            err = 0;
            for (int i = 0; i < int'(v.count); i++) begin
                ea = v.base + 14'(i);
                if (enb_addr[i] !== ea) err++;
            end
            chk("enb_addr_errors", err, 0);
            chk("first_enb_cycle", enb_cyc[0] - t0, 1);
            chk("first_strobe_cycle", byte_cyc[0] - t0, 4);
            err = 0;
            for (int i = 1; i < exp_n; i++) begin
                int gap;
                gap = (i == v.stall_at) ? 11 : ((i % 8 == 0) ? 5 : 3);
                if (byte_cyc[i] - byte_cyc[i-1] != gap) err++;
            end
            chk("strobe_spacing_errors", err, 0);
            err = 0;
            for (int i = 1; i < int'(v.count); i++)
                if (enb_cyc[i] != byte_cyc[8*i-1] + 2) err++;
            chk("next_rd_timing_errors", err, 0);
            chk("done_after_last_strobe", done_cyc - byte_cyc[exp_n-1], 2);
            chk("busy_during_done", done_busy, 1);
        end else begin
            chk("transfer_shape_ok", 0, 1);
        end
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{base: 14'h0010, count: 15'd1, stall_at: 0, poke: 1'b0, first_b: 8'h11, last_b: 8'h88};
        vecs[1] = '{base: 14'h0010, count: 15'd1, stall_at: 3, poke: 1'b0, first_b: 8'h11, last_b: 8'h88};
        vecs[2] = '{base: 14'h3FFF, count: 15'd2, stall_at: 0, poke: 1'b0, first_b: 8'hFF, last_b: 8'h07};
        vecs[3] = '{base: 14'h0100, count: 15'd3, stall_at: 0, poke: 1'b1, first_b: 8'h00, last_b: 8'h09};
        vecs[4] = '{base: 14'h0020, count: 15'd0, stall_at: 0, poke: 1'b0, first_b: 8'h00, last_b: 8'h00};

        rst_i = 1'b1; start_i = 1'b0; base_addr_i = '0; word_count_i = '0; tbr_i = 1'b1;
        repeat (3) @(negedge clk_i);
        chk("rst_enb", enb_o, 0);
        chk("rst_web", web_o, 0);
        chk("rst_addrb", addrb_o, 0);
        chk("rst_tx_wr", tx_wr_o, 0);
        chk("rst_tx_data", tx_data_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        #1 rst_i = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset between byte-3 and byte-4 strobes, then a clean rerun.
        clear_mon();
        start_i = 1'b1; base_addr_i = 14'h0010; word_count_i = 15'd1;
        @(negedge clk_i);
        #1 start_i = 1'b0;
        for (int k = 0; k < 40 && byte_q.size() < 3; k++) begin
            @(negedge clk_i);
            #1;
        end
        chk("pre_reset_strobes", byte_q.size(), 3);
        chk("pre_reset_tx_wr", tx_wr_o, 1);
        rst_i = 1'b1;
        #1;
        chk("mid_rst_tx_wr", tx_wr_o, 0);
        chk("mid_rst_tx_data", tx_data_o, 0);
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_addrb", addrb_o, 0);
        chk("mid_rst_enb", enb_o, 0);
        repeat (2) @(negedge clk_i);
        #1 rst_i = 1'b0;
        clear_mon();
        repeat (40) @(negedge clk_i);
        #1;
        chk("post_rst_strobes", byte_q.size(), 0);
        chk("post_rst_enb", enb_cyc.size(), 0);
        chk("post_rst_done", done_cnt, 0);
        run_vec(vecs[0]);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
